// File: rtl/up_counter_fsm_if.sv
// rtl/up_counter_fsm_if.sv - control/status bundle for up_counter_fsm
interface up_counter_fsm_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             oneshot;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             done;
   logic             busy;

   modport master (
      output start, en, load, load_value, oneshot,
      input  q, tc, done, busy
   );

   modport slave (
      input  start, en, load, load_value, oneshot,
      output q, tc, done, busy
   );
endinterface

// File: rtl/up_counter_fsm.sv
// rtl/up_counter_fsm.sv - programmable 0..MAX up counter; one-shot stop mode compiled in by UP_COUNTER_ONESHOT_EN
module up_counter_fsm #(
   parameter int WIDTH = 4,
   parameter int MAX   = 15
) (
   input  logic           clk,
   input  logic           reset,
   up_counter_fsm_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_r, q_nxt;
   logic [WIDTH-1:0] load_sat;
   logic             busy_r;
   logic             stop_en;

`ifdef UP_COUNTER_ONESHOT_EN
   assign stop_en = bus.oneshot;
`else
   logic unused_oneshot;
   assign unused_oneshot = bus.oneshot;
   assign stop_en        = 1'b0;
`endif

   // Loads clamp to MAX so q can never leave the 0..MAX range.
   assign load_sat = (bus.load_value > MAX_Q) ? MAX_Q : bus.load_value;

   always_comb begin
      state_nxt = state;
      q_nxt     = q_r;
      if (bus.load) begin
         q_nxt = load_sat;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  q_nxt     = '0;
                  state_nxt = COUNT;
               end
            end
            COUNT: begin
               if (bus.start) begin
                  q_nxt = '0;
               end else if (bus.en) begin
                  if (q_r != MAX_Q)
                     q_nxt = q_r + WIDTH'(1);
                  else if (stop_en)
                     state_nxt = DONE;
                  else
                     q_nxt = '0;
               end
            end
            DONE: begin
               if (bus.start) begin
                  q_nxt     = '0;
                  state_nxt = COUNT;
               end
            end
            default: begin
               state_nxt = IDLE;
               q_nxt     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         q_r    <= '0;
         busy_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         q_r    <= q_nxt;
         busy_r <= (state_nxt == COUNT);
      end
   end

`ifdef UP_COUNTER_ONESHOT_EN
   logic done_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         done_r <= 1'b0;
      else
         done_r <= (state_nxt == DONE);
   end

   assign bus.done = done_r;
`else
   assign bus.done = 1'b0;
`endif

   // tc flags the edge on which a wrap or one-shot stop will happen.
   assign bus.tc   = (state == COUNT) & bus.en & (q_r == MAX_Q) & ~bus.load & ~bus.start;
   assign bus.q    = q_r;
   assign bus.busy = busy_r;
endmodule

// File: doc/up_counter_fsm.md
# up_counter_fsm

Programmable up counter for the sequential HDL lab set, complementing the existing 4-bit down counter. It counts 0 → MAX under a start/enable handshake and supports synchronous load and a terminal-count flag. An optional one-shot mode stops at MAX instead of wrapping. It sits alongside the down counter as the up-direction timing/event source for lab datapaths and testbenches.

## Interface

Parameters:
- WIDTH, 4, counter width in bits.
- MAX, 15, terminal count value. Legal range is 1 to 2^WIDTH−1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- start  input  1  starts a count run from IDLE or DONE.
- en  input  1  count enable. Sampled only in COUNT.
- load  input  1  synchronous load request.
- load_value  input  WIDTH  value applied on load.
- oneshot  input  1  selects stop-at-MAX instead of wrap. Honoured only when the one-shot mode is compiled in (see Configuration).
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
- done  output  1  one-shot run complete, registered.
- busy  output  1  high while in COUNT, registered state decode.

## Operation

States: IDLE, COUNT, DONE.

Reset:
- State is IDLE.
- q = 0, done = 0, busy = 0, tc = 0.

Per-edge priority: reset > load > start > en.
- load (any state): q ← min(load_value, MAX). The state is unchanged and no count occurs that cycle.
- IDLE, start=1: q ← 0, go to COUNT.
- IDLE, start=0: hold q.
- COUNT, en=0: hold q and state.
- COUNT, en=1, q<MAX: q ← q+1.
- COUNT, en=1, q==MAX, wrap mode: q ← 0, stay in COUNT.
- COUNT, en=1, q==MAX, one-shot mode: q holds MAX, go to DONE.
- COUNT, start=1: restart, q ← 0. start has priority over en.
- DONE: q holds MAX and done=1.
- DONE, start=1: q ← 0, done ← 0, go to COUNT.
- DONE with load: q loads, stays in DONE.

Outputs:
- tc = (state==COUNT) & en & (q==MAX) & ~load & ~start. It marks the edge on which a wrap or stop will occur.
- Arithmetic is unsigned, modulo MAX+1. q never exceeds MAX.

## Timing

- start to first increment: start sampled at edge N gives q=0 after N. With en=1, q=1 after N+1.
- Full wrap period with en continuously high is MAX+1 cycles. tc is high for exactly 1 cycle per period.
- done rises on the same edge the state enters DONE, and clears on the edge start is sampled.
- Reset asserted mid-count forces all outputs to their reset values immediately, without waiting for clk. After deassertion, the block waits in IDLE for start.
- load together with en=1 at q==MAX: the load wins, there is no wrap, and tc=0.

## Configuration

- UP_COUNTER_ONESHOT_EN defined: the oneshot input selects stop-at-MAX, and the DONE state is reachable.
- UP_COUNTER_ONESHOT_EN undefined: oneshot is ignored, the counter always wraps, DONE is never entered, and done is tied to 0.

## Test plan

- Reset and free run (MAX=15, wrap mode): hold reset 20 ns, then start=1 for 1 cycle, en=1. Required response: q=0,1,…,15,0,1; tc high only in the q=15 cycle; busy=1.
- Enable gating: en toggled 0/1 every other cycle from q=3. Required response: q advances only on en=1 edges, 3,3,4,4,5.
- Load with saturation (MAX=9): at q=4 apply load with load_value=7, giving q=7. Then load with load_value=12, giving q=9. The next enabled edge gives q=0 and tc fired on the q=9 cycle.
- One-shot (macro defined, MAX=5, oneshot=1): start, then en=1. Required response: q runs 0..5, then holds at 5 with done=1 and busy=0. A further start gives done=0 and q=0.
- Reset mid-operation: assert reset asynchronously at q=6 between clock edges. Required response: q=0 and busy=0 before the next edge. After release, q stays 0 until start.
- Macro undefined (MAX=5, oneshot=1): the counter wraps 5 → 0 and done stays 0 throughout.
